audio_mixer: RTL and testbench

//  Upstream feeder for the i2s audio output FIFO. Paces output at the audio sample rate.

---
 rtl/audio_pkg.sv | 35 +++
 rtl/mix_scale_sat.sv | 45 ++++
 rtl/audio_mixer.sv | 192 +++++++++++++++++++
 tb/tb_audio_mixer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, FSM encoding and saturation helper for audio_mixer
package audio_pkg;

  // Per-channel sample width and packed stereo word width
  localparam int SAMPLE_W = 32;
  localparam int STEREO_W = 2 * SAMPLE_W;

  // Width of the value handed to sat(); wide enough for any scaled accumulator
  localparam int SAT_IN_W = 128;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SCALE = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Rails of a signed SAMPLE_W value, expressed at SAT_IN_W
  localparam logic signed [SAT_IN_W-1:0] SAT_MAX =
    {{(SAT_IN_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN =
    {{(SAT_IN_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  // Clamp a wide signed value to the signed SAMPLE_W range instead of wrapping
  function automatic logic signed [SAMPLE_W-1:0] sat(input logic signed [SAT_IN_W-1:0] x);
    if (x > SAT_MAX) begin
      return {1'b0, {(SAMPLE_W - 1){1'b1}}};
    end else if (x < SAT_MIN) begin
      return {1'b1, {(SAMPLE_W - 1){1'b0}}};
    end
    return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/mix_scale_sat.sv
// rtl/mix_scale_sat.sv - one channel of master-volume scaling with saturation and output register
module mix_scale_sat
  import audio_pkg::*;
#(
  parameter int ACC_W = SAMPLE_W + 4
)(
  input  logic                       clk,
  input  logic                       aclr_n,
  input  logic                       i_load,
  input  logic signed [ACC_W-1:0]    i_acc,
  input  logic        [8:0]          i_vol,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  // Product needs accumulator width plus a 10-bit signed view of the 9-bit gain
  localparam int PROD_W = ACC_W + 10;

  logic signed [PROD_W-1:0]   w_acc_x;
  logic signed [PROD_W-1:0]   w_vol_x;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_shift;
  logic signed [SAT_IN_W-1:0] w_wide;
  logic signed [SAMPLE_W-1:0] r_sample;

  // Gain is unsigned: a zero MSB keeps it positive in the signed multiply
  assign w_acc_x = PROD_W'(i_acc);
  assign w_vol_x = PROD_W'($signed({1'b0, i_vol}));
  assign w_prod  = w_acc_x * w_vol_x;

  // 256 is unity, so drop 8 fraction bits; arithmetic shift rounds toward -inf
  assign w_shift = w_prod >>> 8;
  assign w_wide  = SAT_IN_W'(w_shift);

  // Capture the clipped result when the sequencer is in its scale cycle
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_sample <= '0;
    end else if (i_load) begin
      r_sample <= sat(w_wide);
    end
  end

  assign o_sample = r_sample;

endmodule

// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - sample-rate paced stereo voice mixer feeding the i2s FIFO; optional VOICE_MUTE_EN
module audio_mixer
  import audio_pkg::*;
#(
  parameter  int NUM_VOICES      = 8,
  parameter  int CLKS_PER_SAMPLE = 1042,
  localparam int SEL_W           = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
)(
  input  logic                       clk,
  input  logic                       aclr_n,
  input  logic                       enable,
  input  logic [8:0]                 master_vol,
  output logic [SEL_W-1:0]           voice_sel,
  output logic                       voice_rd,
  input  logic signed [SAMPLE_W-1:0] voice_l,
  input  logic signed [SAMPLE_W-1:0] voice_r,
  output logic [STEREO_W-1:0]        sample,
  output logic                       wrreq,
  input  logic                       wrfull,
  output logic                       overrun,
  input  logic                       clear_overrun,
`ifdef VOICE_MUTE_EN
  input  logic [NUM_VOICES-1:0]      voice_mute,
`endif
  output logic                       busy
);

  // Accumulator wide enough that summing NUM_VOICES full-scale samples never wraps
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = $clog2(NUM_VOICES + 1);
  localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_RD = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VOICES);

  logic [CNT_W-1:0]           r_cnt;
  logic                       w_tick;
  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc_l;
  logic signed [ACC_W-1:0]    r_acc_r;
  logic                       w_start;
  logic                       w_mute;
  logic signed [ACC_W-1:0]    w_add_l;
  logic signed [ACC_W-1:0]    w_add_r;
  logic                       w_ovr_set;
  logic                       r_overrun;
  logic signed [SAMPLE_W-1:0] w_sample_l;
  logic signed [SAMPLE_W-1:0] w_sample_r;

  // Sample-rate pacer: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_tick = enable && (r_cnt == CNT_LAST);

  // A new frame starts from IDLE, or from WRITE when the next tick arrives first
  assign w_start = w_tick && ((r_state == IDLE) || (r_state == WRITE));

  // Sequencer state register
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next-state: a blocked WRITE is abandoned for the newer frame at the next tick
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_nxt = FETCH;
      FETCH:   if (r_idx == IDX_LAST) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = WRITE;
      WRITE: begin
        if (w_tick) begin
          w_state_nxt = FETCH;
        end else if (!wrfull) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer outputs: reads on the first NUM_VOICES FETCH cycles, write strobe gated by full
  always_comb begin
    voice_rd  = 1'b0;
    voice_sel = '0;
    wrreq     = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      FETCH: begin
        if (r_idx <= IDX_LAST_RD) begin
          voice_rd  = 1'b1;
          voice_sel = r_idx[SEL_W-1:0];
        end
      end
      WRITE:   wrreq = !wrfull;
      default: ;
    endcase
  end

`ifdef VOICE_MUTE_EN
  logic [SEL_W-1:0] r_acc_sel;

  // Remember which voice was addressed so its mute bit lines up with the returned data
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_acc_sel <= '0;
    end else if (voice_rd) begin
      r_acc_sel <= voice_sel;
    end
  end

  assign w_mute = voice_mute[r_acc_sel];
`else
  assign w_mute = 1'b0;
`endif

  assign w_add_l = w_mute ? '0 : ACC_W'(voice_l);
  assign w_add_r = w_mute ? '0 : ACC_W'(voice_r);

  // Fetch index and accumulators; data lags the read by one cycle, so index 1..NV accumulates
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (w_start) begin
      r_idx   <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (r_state == FETCH) begin
      if (r_idx != '0) begin
        r_acc_l <= r_acc_l + w_add_l;
        r_acc_r <= r_acc_r + w_add_r;
      end
      if (r_idx != IDX_LAST) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // A tick is lost when a frame is still being built or a finished one cannot be written
  assign w_ovr_set = w_tick && ((r_state == FETCH) || (r_state == SCALE) ||
                                ((r_state == WRITE) && wrfull));

  // Sticky overrun flag; a new drop takes priority over a clear in the same cycle
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (clear_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

  mix_scale_sat #(.ACC_W(ACC_W)) u_scale_l (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .i_load   (r_state == SCALE),
    .i_acc    (r_acc_l),
    .i_vol    (master_vol),
    .o_sample (w_sample_l)
  );

  mix_scale_sat #(.ACC_W(ACC_W)) u_scale_r (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .i_load   (r_state == SCALE),
    .i_acc    (r_acc_r),
    .i_vol    (master_vol),
    .o_sample (w_sample_r)
  );

  assign sample = {w_sample_l, w_sample_r};

endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - self-checking bench for audio_mixer; VOICE_MUTE_EN adds a mute case
module tb_audio_mixer;

  localparam int NV  = 8;
  localparam int CPS = 1042;
  // Edges from release to first wrreq: tick in cycle CPS-1, wrreq NV+3 cycles later
  localparam int FIRST_WR = CPS - 1 + NV + 3;

  typedef struct {
    int l0;
    int ls;
    int r0;
    int rs;
    int vol;
    int el;
    int er;
  } vec_t;

  logic               clk = 1'b0;
  logic               aclr_n;
  logic               enable;
  logic [8:0]         master_vol;
  logic [2:0]         voice_sel;
  logic               voice_rd;
  logic signed [31:0] voice_l = '0;
  logic signed [31:0] voice_r = '0;
  logic [63:0]        sample;
  logic               wrreq;
  logic               wrfull;
  logic               overrun;
  logic               clear_overrun;
  logic               busy;
  logic [NV-1:0]      voice_mute;

  logic signed [31:0] vl [NV];
  logic signed [31:0] vr [NV];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          wr_count = 0;
  int          wr_cyc  = 0;
  int          rd_run  = 0;
  int          rd_first = 0;
  bit          prev_rd = 1'b0;
  bit          sel_bad = 1'b0;
  bit          lat_chk = 1'b1;
  bit          ov_seen = 1'b0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_pop;
  vec_t        tbl [9];

  audio_mixer #(.NUM_VOICES(NV), .CLKS_PER_SAMPLE(CPS)) dut (
    .clk           (clk),
    .aclr_n        (aclr_n),
    .enable        (enable),
    .master_vol    (master_vol),
    .voice_sel     (voice_sel),
    .voice_rd      (voice_rd),
    .voice_l       (voice_l),
    .voice_r       (voice_r),
    .sample        (sample),
    .wrreq         (wrreq),
    .wrfull        (wrfull),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
`ifdef VOICE_MUTE_EN
    .voice_mute    (voice_mute),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Voice store with one-cycle read latency
  always @(posedge clk) begin
    if (voice_rd) begin
      voice_l <= vl[voice_sel];
      voice_r <= vr[voice_sel];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor and scoreboard, sampling on the falling edge
  always @(negedge clk) begin
    if (overrun) ov_seen = 1'b1;
    if (voice_rd) begin
      if (!prev_rd) begin
        rd_run   = 0;
        rd_first = cyc;
        sel_bad  = 1'b0;
      end
      if (int'(voice_sel) != rd_run) sel_bad = 1'b1;
      rd_run++;
    end
    prev_rd = voice_rd;
    if (wrreq) begin
      wr_count++;
      wr_cyc = cyc;
      if (wrfull) begin
        n_tests++;
        n_fail++;
        $display("FAIL wrreq_while_full: wrreq=1 with wrfull=1 at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wrreq: sample %0h with no expectation queued", sample);
      end else begin
        exp_pop = exp_q.pop_front();
        check("sample", sample, exp_pop);
      end
      check("voice_reads", sel_bad ? 64'hFFFF : 64'(rd_run), 64'(NV));
      if (lat_chk) check("rd_to_wrreq", 64'(cyc - rd_first), 64'(NV + 2));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < NV; i++) begin
      vl[i] = v.l0 + v.ls * i;
      vr[i] = v.r0 + v.rs * i;
    end
    master_vol = 9'(v.vol);
  endtask

  task automatic wait_wr(input int n0, input int budget);
    int k;
    k = 0;
    while (wr_count == n0 && k < budget) begin
      step(1);
      k++;
    end
    check("wrreq_seen", 64'(wr_count > n0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_voice_sel"}, 64'(voice_sel), 64'd0);
    check({tag, "_voice_rd"},  64'(voice_rd),  64'd0);
    check({tag, "_sample"},    sample,         64'd0);
    check({tag, "_wrreq"},     64'(wrreq),     64'd0);
    check({tag, "_overrun"},   64'(overrun),   64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    int n0;
    int prev;
    int t0;

    tbl[0] = '{1000, 1000, -1000, -1000, 256, 36000, -36000};
    tbl[1] = '{32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 256, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    tbl[2] = '{32'h8000_0000, 0, 32'h8000_0000, 0, 256, 32'h8000_0000, 32'h8000_0000};
    tbl[3] = '{1000, 0, -1000, 0, 128, 4000, -4000};
    tbl[4] = '{1000, 0, -1000, 0, 0, 0, 0};
    tbl[5] = '{1000, 0, -1000, 0, 511, 15968, -15969};
    tbl[6] = '{32'h7FFF_FFFF, 0, 32'h8000_0000, 0, 511, 32'h7FFF_FFFF, 32'h8000_0000};
    tbl[7] = '{1000, 0, -1000, 0, 1, 31, -32};
    tbl[8] = '{-3, 5, 7, -2, 300, 135, 0};

    aclr_n        = 1'b0;
    enable        = 1'b0;
    master_vol    = '0;
    wrfull        = 1'b0;
    clear_overrun = 1'b0;
    voice_mute    = '0;
    t0            = 0;
    step(3);
    check_all_zero("reset");

    // Table-driven frames back to back at the sample rate
    enable = 1'b1;
    for (int j = 0; j < 9; j++) begin
      load(tbl[j]);
      exp_q.push_back({tbl[j].el, tbl[j].er});
      n0   = wr_count;
      prev = wr_cyc;
      if (j == 0) begin
        aclr_n = 1'b1;
        t0     = cyc;
      end
      wait_wr(n0, 2 * CPS);
      if (j == 0) check("first_latency", 64'(wr_cyc - t0), 64'(FIRST_WR));
      else        check("period", 64'(wr_cyc - prev), 64'(CPS));
      check("overrun_idle", 64'(overrun), 64'd0);
    end

    // FIFO held full across two ticks: no write, frame dropped, newest frame written on release
    load(tbl[0]);
    lat_chk = 1'b0;
    wrfull  = 1'b1;
    n0      = wr_count;
    step(2100);
    check("full_no_wrreq", 64'(wr_count), 64'(n0));
    check("full_overrun", 64'(overrun), 64'd1);
    exp_q.push_back({32'sd36000, -32'sd36000});
    wrfull = 1'b0;
    wait_wr(n0, 5);
    check("overrun_sticky", 64'(overrun), 64'd1);
    clear_overrun = 1'b1;
    step(1);
    clear_overrun = 1'b0;
    check("overrun_cleared", 64'(overrun), 64'd0);

    // Clear held high while a drop happens: the drop must still show
    clear_overrun = 1'b1;
    wrfull        = 1'b1;
    ov_seen       = 1'b0;
    n0            = wr_count;
    step(2100);
    check("set_wins", 64'(ov_seen), 64'd1);
    exp_q.push_back({32'sd36000, -32'sd36000});
    wrfull = 1'b0;
    wait_wr(n0, 5);
    clear_overrun = 1'b0;
    step(1);
    check("overrun_after_clear", 64'(overrun), 64'd0);
    lat_chk = 1'b1;

    // Reset asserted mid-fetch: outputs clear at once, no partial write
    n0 = 0;
    while (!voice_rd && n0 < 2 * CPS) begin
      step(1);
      n0++;
    end
    check("fetch_seen", 64'(voice_rd), 64'd1);
    step(2);
    aclr_n = 1'b0;
    #1;
    check_all_zero("midreset");
    n0 = wr_count;
    step(20);
    check("reset_no_wrreq", 64'(wr_count), 64'(n0));
    load(tbl[3]);
    exp_q.push_back({32'sd4000, -32'sd4000});
    aclr_n = 1'b1;
    t0     = cyc;
    wait_wr(n0, 2 * CPS);
    check("reset_resume_latency", 64'(wr_cyc - t0), 64'(FIRST_WR));

    // Pacer disabled: nothing starts; re-enabling restarts the count from zero
    enable = 1'b0;
    n0     = wr_count;
    step(1500);
    check("disabled_no_wrreq", 64'(wr_count), 64'(n0));
    check("disabled_idle", 64'(busy), 64'd0);
    load(tbl[5]);
    exp_q.push_back({32'sd15968, -32'sd15969});
    enable = 1'b1;
    t0     = cyc;
    wait_wr(n0, 2 * CPS);
    check("enable_latency", 64'(wr_cyc - t0), 64'(FIRST_WR));

`ifdef VOICE_MUTE_EN
    // Voices 0..3 muted: 5000+6000+7000+8000
    voice_mute = 8'h0F;
    load(tbl[0]);
    exp_q.push_back({32'sd26000, -32'sd26000});
    n0 = wr_count;
    wait_wr(n0, 2 * CPS);
    voice_mute = '0;
`endif

    step(2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
